// File: rtl/key_debounce.sv
// Per-key push-button conditioner: polarity normalisation, 2-FF synchronizer,
// stability counter, debounced level and single-cycle press/release strobes.
module key_debounce #(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [N_KEYS-1:0] key_raw_i,
    output logic [N_KEYS-1:0] key_level_o,
    output logic [N_KEYS-1:0] key_press_o,
    output logic [N_KEYS-1:0] key_release_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] w_keyN;
    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;
    logic [N_KEYS-1:0] r_stable;
    logic [N_KEYS-1:0] r_press;
    logic [N_KEYS-1:0] r_release;
    logic [CNT_W-1:0]  r_cnt [N_KEYS];

    // Normalise so that 1 always means "pressed" before the synchronizer.
    assign w_keyN = (KEY_ACTIVE_LOW != 0) ? ~key_raw_i : key_raw_i;

    // A new level is accepted only after sync2 has disagreed with the stable
    // level for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_stable  <= '0;
            r_press   <= '0;
            r_release <= '0;
            for (int k = 0; k < N_KEYS; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_sync1 <= w_keyN;
            r_sync2 <= r_sync1;
            for (int k = 0; k < N_KEYS; k++) begin
                r_press[k]   <= 1'b0;
                r_release[k] <= 1'b0;
                if (r_sync2[k] == r_stable[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == CNT_MAX) begin
                    r_stable[k]  <= r_sync2[k];
                    r_cnt[k]     <= '0;
                    r_press[k]   <= r_sync2[k];
                    r_release[k] <= ~r_sync2[k];
                end else begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign key_level_o   = r_stable;
    assign key_press_o   = r_press;
    assign key_release_o = r_release;

endmodule
